// File: rtl/enemy_agent.sv
// enemy_agent: one enemy slot. Holds position/type/hp/invulnerability and,
// on each frame tick, walks the four sprite corners against the shared level
// ROM port before committing a move or bouncing back.
module enemy_agent #(
  parameter int COORD_W       = 10,
  parameter int SPRITE        = 32,
  parameter int OFFSCREEN     = 700,
  parameter int HP_W          = 3,
  parameter int STEP_SLOW     = 2,
  parameter int STEP_FAST     = 4,
  parameter int FAST_TYPE     = 3,
  parameter int INVULN_FRAMES = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_clk,
  input  logic               spawn,
  input  logic [COORD_W-1:0] spawn_x,
  input  logic [COORD_W-1:0] spawn_y,
  input  logic [1:0]         spawn_type,
  input  logic [HP_W-1:0]    spawn_hp,
  input  logic [2:0]         dir,
  input  logic               damage,
  input  logic               probe_wall,
  output logic [COORD_W-1:0] probe_x,
  output logic [COORD_W-1:0] probe_y,
  output logic [COORD_W-1:0] Enemy_X,
  output logic [COORD_W-1:0] Enemy_Y,
  output logic               active,
  output logic [1:0]         Enemy_Type,
  output logic [HP_W-1:0]    hp,
  output logic               invuln,
  output logic               busy
);

  localparam int INV_W = $clog2(INVULN_FRAMES + 1);
  localparam logic [COORD_W-1:0] OFF_C  = COORD_W'(OFFSCREEN);
  localparam logic [COORD_W-1:0] CORNER = COORD_W'(SPRITE - 1);

  typedef enum logic [2:0] {IDLE, P0, P1, P2, P3, COMMIT} state_t;
  state_t state, state_nxt;

  logic               frame_q, damage_q;
  logic               frame_edge, dmg_ok, lethal;
  logic [INV_W-1:0]   inv_cnt;
  logic [COORD_W-1:0] step, dx_c, dy_c;
  logic [COORD_W-1:0] dx, dy, cx, cy;
  logic               hit;

  assign frame_edge = frame_clk & ~frame_q;
  // a hit only lands on a live, vulnerable enemy, and a same-cycle spawn discards it
  assign dmg_ok     = damage & ~damage_q & active & (inv_cnt == '0) & ~spawn;
  assign lethal     = dmg_ok & (hp == HP_W'(1));
  assign invuln     = (inv_cnt != '0);
  assign busy       = (state != IDLE);

  // per-frame displacement from type and direction (two's complement, wraps)
  always_comb begin
    step = (Enemy_Type == 2'(FAST_TYPE)) ? COORD_W'(STEP_FAST) : COORD_W'(STEP_SLOW);
    dx_c = '0;
    dy_c = '0;
    case (dir)
      3'd1:    dx_c = -step;
      3'd2:    dx_c = step;
      3'd3:    dy_c = step;
      3'd4:    dy_c = -step;
      default: ;
    endcase
  end

  // probe sequencer next state; spawn and a lethal hit both abort to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_edge && active) state_nxt = P0;
      P0:      state_nxt = P1;
      P1:      state_nxt = P2;
      P2:      state_nxt = P3;
      P3:      state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (spawn || lethal) state_nxt = IDLE;
  end

  // state register
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // datapath; later assignments take priority (commit < damage < spawn)
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_q    <= 1'b0;
      damage_q   <= 1'b0;
      inv_cnt    <= '0;
      Enemy_X    <= OFF_C;
      Enemy_Y    <= OFF_C;
      probe_x    <= OFF_C;
      probe_y    <= OFF_C;
      active     <= 1'b0;
      Enemy_Type <= '0;
      hp         <= '0;
      dx         <= '0;
      dy         <= '0;
      cx         <= '0;
      cy         <= '0;
      hit        <= 1'b0;
    end else begin
      frame_q  <= frame_clk;
      damage_q <= damage;
      // every frame edge ages the invulnerability window, even while probing
      if (frame_edge && inv_cnt != '0) inv_cnt <= inv_cnt - INV_W'(1);

      case (state)
        IDLE: if (state_nxt == P0) begin
          dx      <= dx_c;
          dy      <= dy_c;
          cx      <= Enemy_X + dx_c;
          cy      <= Enemy_Y + dy_c;
          probe_x <= Enemy_X + dx_c;
          probe_y <= Enemy_Y + dy_c;
        end
        P0: begin
          hit     <= probe_wall;
          probe_x <= cx + CORNER;
          probe_y <= cy;
        end
        P1: begin
          hit     <= hit | probe_wall;
          probe_x <= cx;
          probe_y <= cy + CORNER;
        end
        P2: begin
          hit     <= hit | probe_wall;
          probe_x <= cx + CORNER;
          probe_y <= cy + CORNER;
        end
        P3: hit <= hit | probe_wall;
        COMMIT: begin
          if (hit) begin
            Enemy_X <= Enemy_X - dx;
            Enemy_Y <= Enemy_Y - dy;
          end else begin
            Enemy_X <= cx;
            Enemy_Y <= cy;
          end
        end
        default: ;
      endcase

      if (dmg_ok) begin
        if (lethal) begin
          active  <= 1'b0;
          Enemy_X <= OFF_C;
          Enemy_Y <= OFF_C;
        end else begin
          hp      <= hp - HP_W'(1);
          inv_cnt <= INV_W'(INVULN_FRAMES);
        end
      end

      if (spawn) begin
        inv_cnt <= '0;
        if (spawn_type != 2'd0) begin
          Enemy_X    <= spawn_x;
          Enemy_Y    <= spawn_y;
          Enemy_Type <= spawn_type;
          hp         <= (spawn_hp == '0) ? HP_W'(1) : spawn_hp;
          active     <= 1'b1;
        end else begin
          Enemy_X    <= OFF_C;
          Enemy_Y    <= OFF_C;
          Enemy_Type <= '0;
          hp         <= '0;
          active     <= 1'b0;
        end
      end
    end
  end

endmodule
